cpu_multicycle: RTL and testbench

Parametrised multi-cycle RV32I-subset core; successor to the single-cycle cpu top.
- Replaces the combinational single-cycle datapath with a state machine.
- Talks to separate instruction and data memories over req/ready handshakes, so memories may have variable latency.
- Keeps a 32-entry register file internally and exposes x10 as a0, as before.

---
 rtl/cpu_multicycle.sv | 341 ++++++++++++++++++++++++++++++++++
 tb/tb_cpu_multicycle.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_multicycle.sv
// cpu_multicycle
//
// Multi-cycle RV32I-subset core. Each instruction walks through
// FETCH -> DECODE -> EXECUTE -> (MEM) -> (WB). Instruction and data memories
// are separate and are accessed over req/ready handshakes, so they may have
// any latency. The 32-entry register file lives inside the core and x10 is
// exported continuously as a0.
//
// Supported: ADD SUB AND OR SLT ADDI ANDI ORI SLTI LUI LW SW BEQ BNE JAL JALR.
// Anything else, a misaligned jump/branch target, or a misaligned LW/SW
// address stops the core in HALT until the next reset.
//
// Parameters:
//   DATA_WIDTH     register / data bus width (decoding assumes 32)
//   ADDRESS_WIDTH  width of the PC and both memory address buses
//   RESET_PC       word-aligned PC loaded on reset
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   imem_req/addr     fetch request and byte address (= pc)
//   imem_ready/rdata  fetch completion and instruction word
//   dmem_req/we       data access request, 1 = store
//   dmem_addr/wdata   word-aligned data address and store data
//   dmem_ready/rdata  access completion and load data
//   a0                register x10
//   halted            core stopped
//
// Optional build macro PERF_COUNTERS_EN adds cycle_count and instret_count
// (64-bit, wrapping). Without it the core behaves identically, minus ports.

module cpu_multicycle #(
    parameter int unsigned              DATA_WIDTH    = 32,
    parameter int unsigned              ADDRESS_WIDTH = 16,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     imem_req,
    output logic [ADDRESS_WIDTH-1:0] imem_addr,
    input  logic                     imem_ready,
    input  logic [DATA_WIDTH-1:0]    imem_rdata,
    output logic                     dmem_req,
    output logic                     dmem_we,
    output logic [ADDRESS_WIDTH-1:0] dmem_addr,
    output logic [DATA_WIDTH-1:0]    dmem_wdata,
    input  logic                     dmem_ready,
    input  logic [DATA_WIDTH-1:0]    dmem_rdata,
    output logic [DATA_WIDTH-1:0]    a0,
`ifdef PERF_COUNTERS_EN
    output logic                     halted,
    output logic [63:0]              cycle_count,
    output logic [63:0]              instret_count
`else
    output logic                     halted
`endif
);

    localparam logic [2:0] S_FETCH   = 3'd0;
    localparam logic [2:0] S_DECODE  = 3'd1;
    localparam logic [2:0] S_EXECUTE = 3'd2;
    localparam logic [2:0] S_MEM     = 3'd3;
    localparam logic [2:0] S_WB      = 3'd4;
    localparam logic [2:0] S_HALT    = 3'd5;

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    logic [2:0]               state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
    logic [31:0]              ir_q, ir_d;
    logic [DATA_WIDTH-1:0]    rs1_val_q, rs1_val_d;
    logic [DATA_WIDTH-1:0]    rs2_val_q, rs2_val_d;
    logic [DATA_WIDTH-1:0]    imm_q, imm_d;
    logic [DATA_WIDTH-1:0]    result_q, result_d;
    logic                     dmem_we_q, dmem_we_d;
    logic [ADDRESS_WIDTH-1:0] dmem_addr_q, dmem_addr_d;
    logic [DATA_WIDTH-1:0]    dmem_wdata_q, dmem_wdata_d;
    logic [DATA_WIDTH-1:0]    reg_file_q [32];
    logic [DATA_WIDTH-1:0]    reg_file_d [32];

    logic [6:0] opcode;
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [6:0] funct7;

    logic [DATA_WIDTH-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_dec;
    logic                  insn_legal;
    logic                  alu_f3_ok;

    logic [DATA_WIDTH-1:0]    alu_b, alu_out, exec_result;
    logic                     is_sub, is_mem, branch_taken, misaligned;
    logic [ADDRESS_WIDTH-1:0] pc_plus4, pc_rel, jalr_target, next_pc, mem_addr;

    assign opcode = ir_q[6:0];
    assign rd     = ir_q[11:7];
    assign funct3 = ir_q[14:12];
    assign rs1    = ir_q[19:15];
    assign rs2    = ir_q[24:20];
    assign funct7 = ir_q[31:25];

    assign imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
    assign imm_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    assign imm_b = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    assign imm_u = {ir_q[31:12], 12'b0};
    assign imm_j = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

    // Requests are suppressed while reset is held so that an in-flight
    // transaction is dropped immediately and never re-issued.
    assign imem_req   = (state_q == S_FETCH) && !rst;
    assign imem_addr  = pc_q;
    assign dmem_req   = (state_q == S_MEM) && !rst;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wdata = dmem_wdata_q;
    assign a0         = reg_file_q[10];
    assign halted     = (state_q == S_HALT);

    // Decode: classify the instruction word as legal or not, and pick the
    // immediate format that the opcode uses. The ALU funct3 set is shared by
    // register and immediate forms (ADD/SUB, AND, OR, SLT).
    always_comb begin
        alu_f3_ok  = (funct3 == 3'b000) || (funct3 == 3'b111) ||
                     (funct3 == 3'b110) || (funct3 == 3'b010);
        insn_legal = 1'b0;
        imm_dec    = imm_i;
        case (opcode)
            OP_REG: begin
                insn_legal = ((funct7 == 7'b0000000) && alu_f3_ok) ||
                             ((funct7 == 7'b0100000) && (funct3 == 3'b000));
            end
            OP_IMM: begin
                insn_legal = alu_f3_ok;
            end
            OP_LUI: begin
                insn_legal = 1'b1;
                imm_dec    = imm_u;
            end
            OP_LOAD: begin
                insn_legal = (funct3 == 3'b010);
            end
            OP_STORE: begin
                insn_legal = (funct3 == 3'b010);
                imm_dec    = imm_s;
            end
            OP_BRANCH: begin
                insn_legal = (funct3 == 3'b000) || (funct3 == 3'b001);
                imm_dec    = imm_b;
            end
            OP_JAL: begin
                insn_legal = 1'b1;
                imm_dec    = imm_j;
            end
            OP_JALR: begin
                insn_legal = (funct3 == 3'b000);
            end
            default: begin
                insn_legal = 1'b0;
            end
        endcase
    end

    // Execute datapath: ALU, branch resolution, next PC and memory address.
    // Only instructions that passed decode reach EXECUTE, so the ALU can key
    // purely off funct3. PC arithmetic is done at address width so it wraps.
    always_comb begin
        is_sub = (opcode == OP_REG) && funct7[5];
        is_mem = (opcode == OP_LOAD) || (opcode == OP_STORE);
        alu_b  = (opcode == OP_REG) ? rs2_val_q : imm_q;
        case (funct3)
            3'b111:  alu_out = rs1_val_q & alu_b;
            3'b110:  alu_out = rs1_val_q | alu_b;
            3'b010:  alu_out = {{(DATA_WIDTH-1){1'b0}}, ($signed(rs1_val_q) < $signed(alu_b))};
            default: alu_out = is_sub ? (rs1_val_q - alu_b) : (rs1_val_q + alu_b);
        endcase

        pc_plus4     = pc_q + ADDRESS_WIDTH'(4);
        pc_rel       = pc_q + imm_q[ADDRESS_WIDTH-1:0];
        jalr_target  = (rs1_val_q[ADDRESS_WIDTH-1:0] + imm_q[ADDRESS_WIDTH-1:0]) &
                       ~ADDRESS_WIDTH'(1);
        mem_addr     = rs1_val_q[ADDRESS_WIDTH-1:0] + imm_q[ADDRESS_WIDTH-1:0];
        branch_taken = funct3[0] ? (rs1_val_q != rs2_val_q) : (rs1_val_q == rs2_val_q);

        case (opcode)
            OP_BRANCH: next_pc = branch_taken ? pc_rel : pc_plus4;
            OP_JAL:    next_pc = pc_rel;
            OP_JALR:   next_pc = jalr_target;
            default:   next_pc = pc_plus4;
        endcase

        case (opcode)
            OP_LUI:          exec_result = imm_q;
            OP_JAL, OP_JALR: exec_result = DATA_WIDTH'(pc_plus4);
            default:         exec_result = alu_out;
        endcase

        misaligned = is_mem ? (mem_addr[1:0] != 2'b00) : next_pc[1];
    end

    // Control FSM. Every flop holds its value unless the current state says
    // otherwise; the data-bus registers are loaded once in EXECUTE and then
    // held for the whole MEM handshake so they stay stable until ready.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        rs1_val_d    = rs1_val_q;
        rs2_val_d    = rs2_val_q;
        imm_d        = imm_q;
        result_d     = result_q;
        dmem_we_d    = dmem_we_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;
        reg_file_d   = reg_file_q;
        case (state_q)
            S_FETCH: begin
                if (imem_ready) begin
                    ir_d    = imem_rdata;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                rs1_val_d = reg_file_q[rs1];
                rs2_val_d = reg_file_q[rs2];
                imm_d     = imm_dec;
                state_d   = insn_legal ? S_EXECUTE : S_HALT;
            end
            S_EXECUTE: begin
                if (misaligned) begin
                    state_d = S_HALT;
                end else begin
                    pc_d     = next_pc;
                    result_d = exec_result;
                    if (is_mem) begin
                        dmem_we_d    = (opcode == OP_STORE);
                        dmem_addr_d  = mem_addr;
                        dmem_wdata_d = rs2_val_q;
                        state_d      = S_MEM;
                    end else if (opcode == OP_BRANCH) begin
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_MEM: begin
                if (dmem_ready) begin
                    if (dmem_we_q) begin
                        state_d = S_FETCH;
                    end else begin
                        result_d = dmem_rdata;
                        state_d  = S_WB;
                    end
                end
            end
            S_WB: begin
                if (rd != 5'd0) begin
                    reg_file_d[rd] = result_q;
                end
                state_d = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_HALT;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC;
            ir_q         <= '0;
            rs1_val_q    <= '0;
            rs2_val_q    <= '0;
            imm_q        <= '0;
            result_q     <= '0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            reg_file_q   <= '{default: '0};
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            rs1_val_q    <= rs1_val_d;
            rs2_val_q    <= rs2_val_d;
            imm_q        <= imm_d;
            result_q     <= result_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
            reg_file_q   <= reg_file_d;
        end
    end

`ifdef PERF_COUNTERS_EN
    logic [63:0] cycle_count_q, cycle_count_d;
    logic [63:0] instret_count_q, instret_count_d;

    // An instruction retires whenever control returns to FETCH from one of
    // the completing states; HALT never returns, so halted instructions are
    // not counted.
    always_comb begin
        cycle_count_d   = cycle_count_q;
        instret_count_d = instret_count_q;
        if (state_q != S_HALT) begin
            cycle_count_d = cycle_count_q + 64'd1;
        end
        if (((state_q == S_EXECUTE) || (state_q == S_MEM) || (state_q == S_WB)) &&
            (state_d == S_FETCH)) begin
            instret_count_d = instret_count_q + 64'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_count_q   <= '0;
            instret_count_q <= '0;
        end else begin
            cycle_count_q   <= cycle_count_d;
            instret_count_q <= instret_count_d;
        end
    end

    assign cycle_count   = cycle_count_q;
    assign instret_count = instret_count_q;
`endif

endmodule

// File: tb/tb_cpu_multicycle.sv
// tb_cpu_multicycle
//
// Directed bench for cpu_multicycle (RESET_PC = 0x100). Instruction and data
// memories are modelled with configurable handshake latency; each scenario
// reloads the program under reset and checks hand-computed values at exact
// cycle offsets.

module tb_cpu_multicycle;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic [15:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic [31:0] a0;
    logic        halted;

    logic [31:0] imem [256];
    logic [31:0] dmem [256];
    logic [31:0] prog [$];
    int          imem_lat;
    int          dmem_lat;
    int          imem_wait;
    int          dmem_wait;
    int          store_count;
    int          dmem_req_cycles;
    int          check_count;
    int          error_count;
    int          stores_before;

    cpu_multicycle #(
        .DATA_WIDTH   (32),
        .ADDRESS_WIDTH(16),
        .RESET_PC     (16'h0100)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ready(imem_ready),
        .imem_rdata(imem_rdata),
        .dmem_req  (dmem_req),
        .dmem_we   (dmem_we),
        .dmem_addr (dmem_addr),
        .dmem_wdata(dmem_wdata),
        .dmem_ready(dmem_ready),
        .dmem_rdata(dmem_rdata),
        .a0        (a0),
        .halted    (halted)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory responders: ready rises once a request has been held for the
    // configured number of wait cycles.
    assign imem_ready = imem_req && (imem_wait >= imem_lat);
    assign imem_rdata = imem[imem_addr[9:2]];
    assign dmem_ready = dmem_req && (dmem_wait >= dmem_lat);
    assign dmem_rdata = dmem[dmem_addr[9:2]];

    // Wait-cycle counters, data memory storage and handshake bookkeeping.
    always @(posedge clk) begin
        if (rst || !imem_req || imem_ready) imem_wait <= 0;
        else imem_wait <= imem_wait + 1;
        if (rst || !dmem_req || dmem_ready) dmem_wait <= 0;
        else dmem_wait <= dmem_wait + 1;
        if (rst) begin
            for (int i = 0; i < 256; i++) dmem[i] <= '0;
            dmem_req_cycles <= 0;
        end else begin
            if (dmem_req) dmem_req_cycles <= dmem_req_cycles + 1;
            if (dmem_req && dmem_ready && dmem_we) begin
                dmem[dmem_addr[9:2]] <= dmem_wdata;
                store_count <= store_count + 1;
            end
        end
    end

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Holds reset, loads the queued program at 0x100 over a zeroed
    // instruction memory, then releases reset on a falling edge.
    task automatic applyStimulus();
        rst = 1'b1;
        for (int i = 0; i < 256; i++) imem[i] = '0;
        for (int i = 0; i < prog.size(); i++) imem[64 + i] = prog[i];
        prog.delete();
        tick(2);
        rst = 1'b0;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        check_count++;
        assert (observed === expected)
        else begin
            error_count++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst         = 1'b1;
        imem_lat    = 0;
        dmem_lat    = 0;
        check_count = 0;
        error_count = 0;
        store_count = 0;
        imem_wait   = 0;
        dmem_wait   = 0;

        $display("[TB] scenario 1: single ADDI, zero-wait fetch");
        prog.push_back(enc_i(12'd5, 5'd0, 3'b000, 5'd10, 7'h13));
        applyStimulus();
        checkOutput("rst_imem_req", imem_req, 1);
        checkOutput("rst_imem_addr", imem_addr, 16'h0100);
        checkOutput("rst_a0", a0, 0);
        checkOutput("rst_halted", halted, 0);
        checkOutput("rst_dmem_req", dmem_req, 0);
        tick(3);
        checkOutput("addi_a0_before_wb", a0, 0);
        tick(1);
        checkOutput("addi_a0", a0, 5);
        checkOutput("addi_next_addr", imem_addr, 16'h0104);
        tick(2);
        checkOutput("zero_word_halted", halted, 1);
        checkOutput("zero_word_no_req", imem_req, 0);
        tick(3);
        checkOutput("halt_pc_frozen", imem_addr, 16'h0104);

        $display("[TB] scenario 2: fetch delayed by 3 cycles");
        imem_lat = 3;
        prog.push_back(enc_i(12'd7, 5'd0, 3'b000, 5'd10, 7'h13));
        applyStimulus();
        for (int i = 0; i < 3; i++) begin
            tick(1);
            checkOutput("wait_imem_req", imem_req, 1);
            checkOutput("wait_imem_addr", imem_addr, 16'h0100);
        end
        tick(1);
        checkOutput("wait_req_dropped", imem_req, 0);
        tick(2);
        checkOutput("wait_a0_cycle6", a0, 0);
        tick(1);
        checkOutput("wait_a0_cycle7", a0, 7);

        $display("[TB] scenario 3: store then load, 2-cycle data latency");
        imem_lat = 0;
        dmem_lat = 2;
        prog.push_back(enc_i(12'h040, 5'd0, 3'b000, 5'd1, 7'h13));
        prog.push_back(enc_i(12'hFF9, 5'd0, 3'b000, 5'd2, 7'h13));
        prog.push_back(enc_s(12'h000, 5'd2, 5'd1));
        prog.push_back(enc_i(12'h000, 5'd1, 3'b010, 5'd10, 7'h03));
        applyStimulus();
        tick(11);
        checkOutput("sw_req", dmem_req, 1);
        checkOutput("sw_we", dmem_we, 1);
        checkOutput("sw_addr", dmem_addr, 16'h0040);
        checkOutput("sw_wdata", dmem_wdata, 32'hFFFFFFF9);
        tick(2);
        checkOutput("sw_req_held", dmem_req, 1);
        checkOutput("sw_addr_held", dmem_addr, 16'h0040);
        tick(1);
        checkOutput("sw_req_done", dmem_req, 0);
        checkOutput("sw_mem_word", dmem[16], 32'hFFFFFFF9);
        tick(3);
        checkOutput("lw_req", dmem_req, 1);
        checkOutput("lw_we", dmem_we, 0);
        tick(4);
        checkOutput("lw_a0", a0, 32'hFFFFFFF9);

        $display("[TB] scenario 4: countdown loop with BNE");
        dmem_lat = 0;
        prog.push_back(enc_i(12'd3, 5'd0, 3'b000, 5'd10, 7'h13));
        prog.push_back(enc_i(12'hFFF, 5'd10, 3'b000, 5'd10, 7'h13));
        prog.push_back(enc_b(13'h1FFC, 5'd0, 5'd10, 3'b001));
        applyStimulus();
        tick(11);
        checkOutput("loop_first_taken_pc", imem_addr, 16'h0104);
        checkOutput("loop_first_a0", a0, 2);
        tick(14);
        checkOutput("loop_exit_pc", imem_addr, 16'h010C);
        checkOutput("loop_exit_a0", a0, 0);
        checkOutput("loop_exit_running", halted, 0);
        tick(2);
        checkOutput("loop_then_halt", halted, 1);

        $display("[TB] scenario 5: x0 writes discarded, misaligned LW");
        prog.push_back(enc_i(12'd1, 5'd0, 3'b000, 5'd10, 7'h13));
        prog.push_back(enc_i(12'd9, 5'd0, 3'b000, 5'd0, 7'h13));
        prog.push_back(enc_r(7'h00, 5'd0, 5'd0, 3'b000, 5'd10));
        prog.push_back(enc_i(12'h042, 5'd0, 3'b000, 5'd1, 7'h13));
        prog.push_back(enc_i(12'h000, 5'd1, 3'b010, 5'd11, 7'h03));
        applyStimulus();
        tick(4);
        checkOutput("x0_setup_a0", a0, 1);
        tick(8);
        checkOutput("x0_add_a0", a0, 0);
        tick(7);
        checkOutput("lw_misaligned_halted", halted, 1);
        checkOutput("lw_misaligned_pc", imem_addr, 16'h0110);
        checkOutput("lw_misaligned_no_dmem", dmem_req_cycles, 0);
        tick(2);
        checkOutput("lw_misaligned_no_fetch", imem_req, 0);

        $display("[TB] scenario 6: mixed ALU, LUI, jumps, branch");
        prog.push_back({20'h12345, 5'd5, 7'h37});
        prog.push_back(enc_i(12'hFFD, 5'd0, 3'b000, 5'd6, 7'h13));
        prog.push_back(enc_r(7'h20, 5'd6, 5'd5, 3'b000, 5'd11));
        prog.push_back(enc_r(7'h00, 5'd5, 5'd6, 3'b010, 5'd7));
        prog.push_back(enc_i(12'hFFF, 5'd5, 3'b010, 5'd8, 7'h13));
        prog.push_back(enc_i(12'h0F0, 5'd6, 3'b111, 5'd9, 7'h13));
        prog.push_back(enc_r(7'h00, 5'd9, 5'd7, 3'b110, 5'd12));
        prog.push_back(enc_r(7'h00, 5'd8, 5'd12, 3'b000, 5'd12));
        prog.push_back(enc_j(21'h8, 5'd1));
        prog.push_back(enc_i(12'h000, 5'd0, 3'b000, 5'd12, 7'h13));
        prog.push_back(enc_i(12'h011, 5'd1, 3'b000, 5'd13, 7'h67));
        prog.push_back(enc_i(12'h000, 5'd0, 3'b000, 5'd12, 7'h13));
        prog.push_back(enc_i(12'h000, 5'd0, 3'b000, 5'd12, 7'h13));
        prog.push_back(enc_b(13'h0008, 5'd0, 5'd0, 3'b000));
        prog.push_back(enc_i(12'h000, 5'd0, 3'b000, 5'd12, 7'h13));
        prog.push_back(enc_r(7'h00, 5'd12, 5'd11, 3'b000, 5'd10));
        prog.push_back(enc_r(7'h00, 5'd13, 5'd10, 3'b000, 5'd10));
        prog.push_back(enc_i(12'h001, 5'd10, 3'b110, 5'd10, 7'h13));
        prog.push_back(enc_r(7'h00, 5'd1, 5'd10, 3'b000, 5'd10));
        applyStimulus();
        for (int i = 0; i < 400 && !halted; i++) tick(1);
        checkOutput("mix_halted", halted, 1);
        checkOutput("mix_a0", a0, 32'h12345345);
        checkOutput("mix_halt_pc", imem_addr, 16'h014C);

        $display("[TB] scenario 7: reset during a stalled store");
        dmem_lat = 1000;
        prog.push_back(enc_i(12'd9, 5'd0, 3'b000, 5'd10, 7'h13));
        prog.push_back(enc_i(12'h080, 5'd0, 3'b000, 5'd1, 7'h13));
        prog.push_back(enc_s(12'h000, 5'd10, 5'd1));
        applyStimulus();
        stores_before = store_count;
        tick(11);
        checkOutput("stall_sw_req", dmem_req, 1);
        checkOutput("stall_sw_wdata", dmem_wdata, 32'd9);
        tick(2);
        rst = 1'b1;
        tick(1);
        checkOutput("midrst_dmem_req", dmem_req, 0);
        checkOutput("midrst_dmem_we", dmem_we, 0);
        checkOutput("midrst_dmem_addr", dmem_addr, 0);
        checkOutput("midrst_dmem_wdata", dmem_wdata, 0);
        checkOutput("midrst_imem_req", imem_req, 0);
        checkOutput("midrst_halted", halted, 0);
        checkOutput("midrst_a0", a0, 0);
        checkOutput("midrst_pc", imem_addr, 16'h0100);
        checkOutput("midrst_no_store", store_count, stores_before);
        dmem_lat = 0;
        rst = 1'b0;
        #1;
        checkOutput("refetch_req", imem_req, 1);
        checkOutput("refetch_addr", imem_addr, 16'h0100);
        tick(4);
        checkOutput("refetch_a0", a0, 9);

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule
